esm_buffer_ctrl: RTL and testbench
==================================

# esm_buffer_ctrl

- Sequencing controller for the ESM instruction buffer; replaces the free-running test counter that today drives the buffer index.
- Accepts instructions through a valid/ready handshake and allocates buffer slots in circular order.
- Issues slots in order to ESM_Core and retires them in order.
- Maintains the valid-entry bitmap and supports a draining flush.

## Interface
Parameters:
- Instruction_word_size, 32, instruction width in bits
- bs, 16, buffer depth in entries; must be a power of two and ≥2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Instr_in  in  Instruction_word_size  incoming instruction; all-zero is a bubble
- in_valid  in  1  Instr_in is presented
- in_ready  out  1  controller can accept this cycle
- buf_we  out  1  write strobe to InstructionBuffer
- buf_index  out  $clog2(bs)  write slot (current wr_ptr)
- issue_valid  out  1  the slot at issue_index is ready for ESM_Core
- issue_ready  in  1  ESM_Core takes the issued slot
- issue_index  out  $clog2(bs)  current iss_ptr
- retire  in  1  retires the oldest issued entry
- flush  in  1  request to discard unissued entries
- valid_entries  out  bs  bit i set = slot i allocated and not yet retired
- count  out  $clog2(bs)+1  number of allocated entries
- full, empty  out  1  count==bs, count==0
- busy  out  1  state != RUN
- err_retire  out  1  sticky: a retire arrived with no issued entry outstanding

## Operation
Pointers:
- wr_ptr (tail), iss_ptr, and hd_ptr (head), each $clog2(bs) bits, wrap modulo bs.
- The order hd ≤ iss ≤ wr always holds, taken circularly.
- outstanding = iss − hd (issued, not retired); pending = wr − iss (allocated, not issued).
- count = outstanding + pending.

Accept:
- An accept is in_valid & in_ready.
- Non-zero Instr_in: buf_we=1 and buf_index=wr_ptr in the same cycle; valid_entries[wr_ptr] sets, wr_ptr increments, count increments.
- Zero Instr_in is a bubble: it is consumed (in_ready honoured), buf_we=0, and no pointer or count changes.

Issue:
- When issue_valid & issue_ready, iss_ptr increments.

Retire:
- When retire=1 and outstanding>0, valid_entries[hd_ptr] clears and hd_ptr increments.
- When retire=1 and outstanding==0, err_retire is set (sticky until reset) and nothing else changes.

FSM states:
- RUN: in_ready = !full; issue_valid = (pending>0).
- DRAIN: entered from RUN when flush=1. in_ready=0, issue_valid=0, retires still processed. Leaves when outstanding==0, or immediately if it is already 0.
- PURGE: one cycle. Clears valid_entries for all pending slots, sets wr_ptr=iss_ptr, and returns to RUN.
- flush while in DRAIN or PURGE is ignored.

Simultaneous events:
- Accept, issue and retire may all occur in one cycle; count changes by (+accept_nonzero − retire_effective).
- When full, in_ready is 0 even if a retire occurs that same cycle; the freed slot becomes usable next cycle.
- A flush arriving in the same cycle as an accept/issue: that accept/issue completes, and the FSM enters DRAIN next cycle.

## Timing
- in_ready, issue_valid, buf_we and buf_index are combinational from registered state and inputs. All other state is registered on posedge clk.
- Latency: an instruction accepted at cycle N can be presented on issue_valid at cycle N+1 at the earliest.
- Sustained throughput is 1 accept + 1 issue + 1 retire per cycle.
- DRAIN lasts max(1, cycles until the last outstanding retire). PURGE lasts exactly 1 cycle, so a flush costs at least 2 cycles with busy=1.

Reset (asynchronous, any state, including mid-DRAIN):
- State = RUN; all pointers 0; valid_entries=0; count=0; empty=1, full=0, busy=0, err_retire=0.
- Resulting outputs: in_ready=1, issue_valid=0, buf_we=0.

## Configuration
- ESM_BUF_CTRL_STATS_EN defined: adds outputs bubble_cnt (32 bits, counts accepted zero instructions) and stall_cnt (32 bits, counts cycles with in_valid=1 and in_ready=0).
  - Both counters saturate at all-ones and reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then 16 non-zero accepts with no issue → count=16, full=1, in_ready=0, valid_entries=16'hFFFF, wr_ptr wraps to 0.
- Interleaved zero/non-zero stream of 8 words (4 zero) → 4 buf_we pulses at indices 0..3, count=4; stats build: bubble_cnt=4.
- 40 instructions with continuous issue_ready=1 and a retire one cycle after each issue → pointers wrap twice, count never exceeds 2, no err_retire.
- 6 allocated, 3 issued, flush with retires at +3,+5,+6 cycles → busy for 7 cycles, then count=0, valid_entries=0, wr_ptr=iss_ptr=hd_ptr=3.
- retire with outstanding=0 → err_retire=1 and stays 1; pointers unchanged.
- Assert rst during DRAIN with 2 outstanding → all outputs at reset values the same cycle; RUN after deassertion.

Source files
------------

// File: rtl/esm_buffer_ctrl.sv
// ESM instruction buffer sequencer: circular slot allocation, in-order issue/retire, draining flush.
// Optional ESM_BUF_CTRL_STATS_EN adds saturating bubble_cnt and stall_cnt outputs.
module esm_buffer_ctrl #(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Instruction_word_size-1:0] Instr_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             buf_we,
    output logic [$clog2(bs)-1:0]            buf_index,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [$clog2(bs)-1:0]            issue_index,
    input  logic                             retire,
    input  logic                             flush,
    output logic [bs-1:0]                    valid_entries,
`ifdef ESM_BUF_CTRL_STATS_EN
    output logic [31:0]                      bubble_cnt,
    output logic [31:0]                      stall_cnt,
`endif
    output logic [$clog2(bs):0]              count,
    output logic                             full,
    output logic                             empty,
    output logic                             busy,
    output logic                             err_retire
);

    // state | meaning
    // RUN   | normal accept / issue / retire
    // DRAIN | intake and issue frozen, waiting for outstanding retires
    // PURGE | one cycle: drop pending slots, wr_ptr snaps back to iss_ptr
    localparam int AW = $clog2(bs);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, PURGE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, iss_ptr, hd_ptr;
    logic [CW-1:0]   out_cnt, pend_cnt;
    logic            accept, acc_nz, iss_fire, ret_eff;
    logic [bs-1:0]   set_mask, clr_mask, purge_mask;

    assign count       = out_cnt + pend_cnt;
    assign full        = (count == CW'(bs));
    assign empty       = (count == '0);
    assign busy        = (state != RUN);
    assign buf_index   = wr_ptr;
    assign issue_index = iss_ptr;

    assign accept   = in_valid & in_ready;
    assign acc_nz   = accept & (|Instr_in);
    assign buf_we   = acc_nz;
    assign iss_fire = issue_valid & issue_ready;
    assign ret_eff  = retire & (out_cnt != '0);

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        issue_valid = 1'b0;
        case (state)
            RUN: begin
                in_ready    = !full;
                issue_valid = (pend_cnt != '0);
                if (flush) state_nxt = DRAIN;
            end
            DRAIN: begin
                // leave once the last outstanding entry retires (or none were left)
                if (out_cnt == CW'(ret_eff)) state_nxt = PURGE;
            end
            PURGE:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // pending slots are the pend_cnt entries starting at iss_ptr
    always_comb begin
        purge_mask = '0;
        for (int i = 0; i < bs; i++) begin
            purge_mask[i] = ({1'b0, AW'(AW'(i) - iss_ptr)} < pend_cnt);
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (acc_nz)  set_mask[wr_ptr] = 1'b1;
        if (ret_eff) clr_mask[hd_ptr] = 1'b1;
        if (state == PURGE) clr_mask = clr_mask | purge_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            wr_ptr        <= '0;
            iss_ptr       <= '0;
            hd_ptr        <= '0;
            out_cnt       <= '0;
            pend_cnt      <= '0;
            valid_entries <= '0;
            err_retire    <= 1'b0;
        end else begin
            state         <= state_nxt;
            valid_entries <= (valid_entries | set_mask) & ~clr_mask;
            out_cnt       <= out_cnt + CW'(iss_fire) - CW'(ret_eff);
            if (iss_fire) iss_ptr <= iss_ptr + AW'(1);
            if (ret_eff)  hd_ptr  <= hd_ptr + AW'(1);
            if (retire && out_cnt == '0) err_retire <= 1'b1;
            if (state == PURGE) begin
                wr_ptr   <= iss_ptr;
                pend_cnt <= '0;
            end else begin
                if (acc_nz) wr_ptr <= wr_ptr + AW'(1);
                pend_cnt <= pend_cnt + CW'(acc_nz) - CW'(iss_fire);
            end
        end
    end

`ifdef ESM_BUF_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (accept && !(|Instr_in) && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
            if (in_valid && !in_ready && stall_cnt != '1)   stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_esm_buffer_ctrl.sv
// Self-checking bench for esm_buffer_ctrl: directed sequences plus random traffic against an occupancy model.
module tb_esm_buffer_ctrl;
    localparam int W  = 32;
    localparam int BS = 16;
    localparam int AW = $clog2(BS);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  instr_in;
    logic          in_valid, issue_ready, retire, flush;
    logic          in_ready, buf_we, issue_valid, full, empty, busy, err_retire;
    logic [AW-1:0] buf_index, issue_index;
    logic [BS-1:0] valid_entries;
    logic [AW:0]   count;
`ifdef ESM_BUF_CTRL_STATS_EN
    logic [31:0]   bubble_cnt, stall_cnt;
`endif

    esm_buffer_ctrl #(.Instruction_word_size(W), .bs(BS)) dut (
        .clk(clk), .rst(rst), .Instr_in(instr_in), .in_valid(in_valid), .in_ready(in_ready),
        .buf_we(buf_we), .buf_index(buf_index), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_index(issue_index), .retire(retire), .flush(flush), .valid_entries(valid_entries),
`ifdef ESM_BUF_CTRL_STATS_EN
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
        .count(count), .full(full), .empty(empty), .busy(busy), .err_retire(err_retire)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference: monotonic sequence numbers for tail/issue/head, phase 0=run 1=drain 2=purge
    int m_wr, m_iss, m_hd, m_phase;
    bit m_err;
    int busy_cycles, we_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_iss = 0; m_hd = 0; m_phase = 0; m_err = 0;
    endtask

    // one clock: drive inputs, check comb + state outputs against model, advance model at the edge
    task automatic step(input bit iv, input logic [W-1:0] ins, input bit ir, input bit rt, input bit fl);
        int pend, outs, cnt;
        bit e_rdy, e_iv, e_we;
        logic [BS-1:0] e_valid;
        in_valid = iv; instr_in = ins; issue_ready = ir; retire = rt; flush = fl;
        #2;
        pend  = m_wr - m_iss;
        outs  = m_iss - m_hd;
        cnt   = pend + outs;
        e_rdy = (m_phase == 0) && (cnt < BS);
        e_iv  = (m_phase == 0) && (pend > 0);
        e_we  = iv && e_rdy && (ins != 0);
        e_valid = '0;
        for (int k = m_hd; k < m_wr; k++) e_valid[k % BS] = 1'b1;
        chk("in_ready", in_ready, e_rdy);
        chk("issue_valid", issue_valid, e_iv);
        chk("buf_we", buf_we, e_we);
        chk("buf_index", buf_index, m_wr % BS);
        chk("issue_index", issue_index, m_iss % BS);
        chk("count", count, cnt);
        chk("full", full, cnt == BS);
        chk("empty", empty, cnt == 0);
        chk("busy", busy, m_phase != 0);
        chk("err_retire", err_retire, m_err);
        chk("valid_entries", valid_entries, e_valid);
        if (e_we) we_pulses++;
        if (busy) busy_cycles++;
        @(posedge clk);
        if (rt && outs == 0) m_err = 1;
        if (m_phase == 2) begin
            m_wr = m_iss;
            m_phase = 0;
        end else begin
            if (m_phase == 1 && outs - ((rt && outs > 0) ? 1 : 0) == 0) m_phase = 2;
            if (m_phase == 0 && fl) m_phase = 1;
        end
        if (e_we) m_wr++;
        if (e_iv && ir) m_iss++;
        if (rt && outs > 0) m_hd++;
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; instr_in = '0; issue_ready = 0; retire = 0; flush = 0;
        rst = 1'b1;
        #2;
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] word;
    bit prev_iss;

    initial begin
        rst = 1'b1;
        in_valid = 0; instr_in = '0; issue_ready = 0; retire = 0; flush = 0;
        model_reset();
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_empty", empty, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // fill all 16 slots with no issue
        for (int i = 0; i < BS; i++) step(1, W'(i + 1), 0, 0, 0);
        step(1, 32'h55, 0, 0, 0);
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_ready", in_ready, 0);
        chk("fill_valid", valid_entries, 16'hFFFF);
        chk("fill_wrap", buf_index, 0);

        // bubbles interleaved with real words
        do_reset();
        we_pulses = 0;
        for (int i = 0; i < 8; i++) step(1, (i % 2 == 0) ? '0 : W'(32'hA000 + i), 0, 0, 0);
        chk("bubble_we", we_pulses, 4);
        chk("bubble_count", count, 4);
        chk("bubble_valid", valid_entries, 16'h000F);
`ifdef ESM_BUF_CTRL_STATS_EN
        chk("bubble_cnt", bubble_cnt, 4);
`endif

        // streaming: issue as soon as possible, retire one cycle after each issue
        do_reset();
        prev_iss = 0;
        for (int i = 0; i < 44; i++) begin
            bit cur_iss;
            cur_iss = issue_valid;
            step(i < 40, W'(i + 100), 1, prev_iss, 0);
            prev_iss = cur_iss;
            chk("stream_cnt_le2", count <= 2, 1);
        end
        chk("stream_err", err_retire, 0);
        chk("stream_wr", buf_index, 40 % BS);
        chk("stream_empty", empty, 1);

        // flush with 3 outstanding and 3 pending
        do_reset();
        for (int i = 0; i < 6; i++) step(1, W'(i + 7), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 1);
        busy_cycles = 0;
        for (int c = 1; c <= 12; c++) step(0, '0, 0, (c == 3 || c == 5 || c == 6), 0);
        chk("flush_busy_cycles", busy_cycles, 7);
        chk("flush_count", count, 0);
        chk("flush_valid", valid_entries, 0);
        chk("flush_wr", buf_index, 3);
        chk("flush_iss", issue_index, 3);

        // retire with nothing outstanding
        step(0, '0, 0, 1, 0);
        chk("err_set", err_retire, 1);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0);
        chk("err_sticky", err_retire, 1);
        chk("err_wr_same", buf_index, 3);

        // async reset in the middle of DRAIN
        do_reset();
        for (int i = 0; i < 3; i++) step(1, W'(i + 9), 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 1);
        step(0, '0, 0, 0, 0);
        chk("drain_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_iv", issue_valid, 0);
        chk("mid_rst_we", buf_we, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", valid_entries, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step(1, 32'h1, 0, 0, 0);
        chk("post_rst_run", busy, 0);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            word = ($urandom_range(3) == 0) ? '0 : W'($urandom);
            step($urandom_range(9) < 7, word, $urandom_range(9) < 6,
                 $urandom_range(9) < 5, $urandom_range(39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
